pool_layer: RTL and testbench

POOL_LAYER -- requirements
Module: pool_layer

---
 rtl/pool_layer.sv | 123 ++++++++++++
 tb/tb_pool_layer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_layer.sv
// pool_layer: 2x2 signed max-pooling over a ReLU feature map.
// A small IDLE/RUN/DONE sequencer walks one output window per clock in
// row-major order and writes the maximum of its four inputs into pool_result.
module pool_layer #(
  parameter int POOL_X          = 24,
  parameter int POOL_Y          = 24,
  parameter int POOL_DATA_WIDTH = 45
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pool_enable,
  input  logic signed [POOL_DATA_WIDTH-1:0] relu_result [POOL_X][POOL_Y],
  output logic signed [POOL_DATA_WIDTH-1:0] pool_result [POOL_X/2][POOL_Y/2],
  output logic                              pool_busy,
  output logic                              pool_done
);

  localparam int OUT_X = POOL_X / 2;
  localparam int OUT_Y = POOL_Y / 2;
  localparam int RW    = (OUT_X > 1) ? $clog2(OUT_X) : 1;
  localparam int CW    = (OUT_Y > 1) ? $clog2(OUT_Y) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(OUT_X - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OUT_Y - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                              state;
  logic [RW-1:0]                       r;
  logic [CW-1:0]                       c;
  logic [RW:0]                         row0;
  logic [RW:0]                         row1;
  logic [CW:0]                         col0;
  logic [CW:0]                         col1;
  logic signed [POOL_DATA_WIDTH-1:0]   top_max;
  logic signed [POOL_DATA_WIDTH-1:0]   bot_max;
  logic signed [POOL_DATA_WIDTH-1:0]   win_max;
  logic                                last_win;
  logic                                write_en;

  // Select the four inputs of the current window and reduce them to a signed maximum
  always_comb begin
    row0    = {r, 1'b0};
    row1    = {r, 1'b1};
    col0    = {c, 1'b0};
    col1    = {c, 1'b1};
    top_max = (relu_result[row0][col1] > relu_result[row0][col0]) ?
              relu_result[row0][col1] : relu_result[row0][col0];
    bot_max = (relu_result[row1][col1] > relu_result[row1][col0]) ?
              relu_result[row1][col1] : relu_result[row1][col0];
    win_max = (bot_max > top_max) ? bot_max : top_max;
  end

  assign last_win  = (r == R_LAST) && (c == C_LAST);
  assign write_en  = (state == RUN) && pool_enable;
  assign pool_busy = (state == RUN);

  // Sequencer: start from IDLE, walk windows c-fastest, park in DONE until enable drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      pool_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pool_done <= 1'b0;
          if (pool_enable) begin
            state <= RUN;
            r     <= '0;
            c     <= '0;
          end
        end
        RUN: begin
          if (!pool_enable) begin
            state <= IDLE;
            r     <= '0;
            c     <= '0;
          end else if (last_win) begin
            state     <= DONE;
            pool_done <= 1'b1;
            r         <= '0;
            c         <= '0;
          end else if (c == C_LAST) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        DONE: begin
          if (!pool_enable) begin
            state     <= IDLE;
            pool_done <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          pool_done <= 1'b0;
        end
      endcase
    end
  end

  // Result map: cleared by reset, otherwise only the active window is written during RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_X; i++) begin
        for (int j = 0; j < OUT_Y; j++) begin
          pool_result[i][j] <= '0;
        end
      end
    end else if (write_en) begin
      pool_result[r][c] <= win_max;
    end
  end

endmodule

// File: tb/tb_pool_layer.sv
// tb_pool_layer: randomized and directed checks of pool_layer against a
// window-index reference model, plus a 4x4 instance for counter wrap.
module tb_pool_layer;

  localparam int X  = 24;
  localparam int Y  = 24;
  localparam int W  = 45;
  localparam int OX = X / 2;
  localparam int OY = Y / 2;
  localparam int N  = OX * OY;
  localparam int SX = 4;
  localparam int SY = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic                en_main = 1'b0;
  logic signed [W-1:0] relu_main [X][Y];
  logic signed [W-1:0] pool_main [OX][OY];
  logic                busy_main;
  logic                done_main;

  logic                en_s = 1'b0;
  logic signed [W-1:0] relu_s [SX][SY];
  logic signed [W-1:0] pool_s [SX/2][SY/2];
  logic                busy_s;
  logic                done_s;

  int checks   = 0;
  int errors   = 0;
  bit check_on = 1'b0;

  int                  m_phase = M_IDLE;
  int                  m_k     = 0;
  logic signed [W-1:0] exp_res [OX][OY];
  logic signed [W-1:0] snap    [OX][OY];

  pool_layer #(.POOL_X(X), .POOL_Y(Y), .POOL_DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .pool_enable(en_main), .relu_result(relu_main),
    .pool_result(pool_main), .pool_busy(busy_main), .pool_done(done_main)
  );

  pool_layer #(.POOL_X(SX), .POOL_Y(SY), .POOL_DATA_WIDTH(W)) dut_s (
    .clk(clk), .rst(rst), .pool_enable(en_s), .relu_result(relu_s),
    .pool_result(pool_s), .pool_busy(busy_s), .pool_done(done_s)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [W-1:0] winMax(int rr, int cc);
    logic signed [W-1:0] m;
    m = relu_main[2*rr][2*cc];
    for (int d = 1; d < 4; d++) begin
      if (relu_main[2*rr + d/2][2*cc + d%2] > m) m = relu_main[2*rr + d/2][2*cc + d%2];
    end
    return m;
  endfunction

  function automatic logic signed [W-1:0] randVal();
    logic [63:0] t;
    int s;
    t = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) begin
      s = int'($urandom_range(0, 8)) - 4;
      return W'(s);
    end
    return t[W-1:0];
  endfunction

  task automatic randomizeMain();
    for (int i = 0; i < X; i++)
      for (int j = 0; j < Y; j++)
        relu_main[i][j] = randVal();
  endtask

  // Reference model: a run is a linear sequence of N window writes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = M_IDLE;
      m_k     = 0;
      for (int i = 0; i < OX; i++)
        for (int j = 0; j < OY; j++)
          exp_res[i][j] = '0;
    end else begin
      case (m_phase)
        M_IDLE: if (en_main) begin m_phase = M_RUN; m_k = 0; end
        M_RUN: begin
          if (!en_main) m_phase = M_IDLE;
          else begin
            exp_res[m_k / OY][m_k % OY] = winMax(m_k / OY, m_k % OY);
            m_k++;
            if (m_k == N) m_phase = M_DONE;
          end
        end
        default: if (!en_main) m_phase = M_IDLE;
      endcase
    end
  end

  // Compare process: every falling edge, outputs must match the model
  always @(negedge clk) begin
    if (check_on) begin
      int br, bc;
      br = 0; bc = 0;
      checkOutput("busy", busy_main, m_phase == M_RUN);
      checkOutput("done", done_main, m_phase == M_DONE);
      for (int i = OX - 1; i >= 0; i--)
        for (int j = OY - 1; j >= 0; j--)
          if (pool_main[i][j] !== exp_res[i][j]) begin br = i; bc = j; end
      checkOutput($sformatf("pool_result[%0d][%0d]", br, bc), pool_main[br][bc], exp_res[br][bc]);
    end
  end

  task automatic applyStimulus(input logic en);
    @(negedge clk);
    en_main = en;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 rst = 1'b1;
    en_main = 1'b0;
    en_s    = 1'b0;
    #2 rst = 1'b0;
  endtask

  // Raise enable and count edges after the start edge until pool_done is seen
  task automatic runFull(input string name);
    int n;
    applyStimulus(1'b1);
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done_main) break;
    end
    checkOutput({name, "_latency"}, n, N);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < SX; i++)
      for (int j = 0; j < SY; j++)
        relu_s[i][j] = W'(i * SX + j);
    for (int i = 0; i < X; i++)
      for (int j = 0; j < Y; j++)
        relu_main[i][j] = W'(i * Y + j);

    #1 rst = 1'b1;
    #20;
    @(negedge clk);
    #2 rst = 1'b0;
    checkOutput("reset_done", done_main, 0);
    checkOutput("reset_busy", busy_main, 0);
    checkOutput("reset_entry", pool_main[5][7], 0);
    check_on = 1'b1;

    // Ramp pattern: every window max is its bottom-right element
    runFull("ramp");
    for (int r = 0; r < OX; r++)
      for (int c = 0; c < OY; c++) begin
        checkOutput("ramp_dut", pool_main[r][c], (2*r + 1) * Y + 2*c + 1);
        checkOutput("ramp_model", exp_res[r][c], (2*r + 1) * Y + 2*c + 1);
      end
    repeat (3) applyStimulus(1'b1);
    repeat (2) applyStimulus(1'b0);

    // Signed windows with ties and all-negative values
    pulseReset();
    randomizeMain();
    relu_main[0][0] = 5;  relu_main[0][1] = -3; relu_main[1][0] = 5;  relu_main[1][1] = 0;
    relu_main[0][2] = -1; relu_main[0][3] = -7; relu_main[1][2] = -2; relu_main[1][3] = -9;
    runFull("signed");
    checkOutput("tie_window", pool_main[0][0], 5);
    checkOutput("neg_window", pool_main[0][1], -1);
    checkOutput("tie_model", exp_res[0][0], 5);
    applyStimulus(1'b0);

    // Abort after ten RUN cycles
    pulseReset();
    randomizeMain();
    repeat (11) applyStimulus(1'b1);
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("abort_busy", busy_main, 0);
    for (int c = 0; c < OY; c++)
      checkOutput("abort_row0", pool_main[0][c], (c < 10) ? winMax(0, c) : 0);
    checkOutput("abort_row1", pool_main[1][0], 0);
    checkOutput("abort_last", pool_main[OX-1][OY-1], 0);
    repeat (20) begin
      applyStimulus(1'b0);
      checkOutput("abort_done", done_main, 0);
    end

    // Asynchronous reset between edges in the middle of a run
    randomizeMain();
    repeat (20) applyStimulus(1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_busy", busy_main, 0);
    checkOutput("async_done", done_main, 0);
    checkOutput("async_entry00", pool_main[0][0], 0);
    checkOutput("async_entry05", pool_main[0][5], 0);
    en_main = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    applyStimulus(1'b0);
    runFull("after_reset");
    checkOutput("after_reset_last", pool_main[OX-1][OY-1], winMax(OX-1, OY-1));

    // DONE freezes results; a re-armed run picks up new inputs
    snap = pool_main;
    randomizeMain();
    repeat (5) applyStimulus(1'b1);
    for (int r = 0; r < OX; r++)
      for (int c = 0; c < OY; c++)
        if (pool_main[r][c] !== snap[r][c] || r == OX-1)
          checkOutput("done_frozen", pool_main[r][c], snap[r][c]);
    applyStimulus(1'b0);
    runFull("rerun");
    checkOutput("rerun_first", pool_main[0][0], winMax(0, 0));
    applyStimulus(1'b0);

    // Random enable traffic
    for (int k = 0; k < 800; k++) begin
      applyStimulus($urandom_range(0, 19) != 0);
      if (!en_main && $urandom_range(0, 1) == 1) randomizeMain();
    end
    applyStimulus(1'b0);

    // 4x4 instance: four RUN cycles and the c wrap into row 1
    pulseReset();
    @(negedge clk);
    en_s = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("small_busy", busy_s, k < 4);
      checkOutput("small_done", done_s, k >= 4);
      for (int idx = 0; idx < 4; idx++)
        checkOutput($sformatf("small_entry%0d_k%0d", idx, k), pool_s[idx/2][idx%2],
                    (idx < k) ? (2*(idx/2) + 1) * SY + 2*(idx%2) + 1 : 0);
    end
    en_s = 1'b0;
    @(negedge clk);
    checkOutput("small_idle_done", done_s, 0);

    check_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
